// File: rtl/mlp_job_arbiter.sv
// Round-robin arbiter that lends one MLP engine to NumReq job sources for a whole job,
// routes the engine's result beats to the owner and audits the beat count of each job.
//
// state | meaning
// Idle  | no job; pick the next requester round-robin from rr_ptr
// Issue | present init/start to the engine until it accepts
// Busy  | engine working; result beats routed to the owner and counted
// Done  | one-cycle done pulse, beat audit, advance rr_ptr
module mlp_job_arbiter #(
   parameter int NumReq      = 4,
   parameter int ResultBeats = 256
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NumReq-1:0]         req_valid_i,
   input  logic [NumReq-1:0]         req_init_i,
   output logic [NumReq-1:0]         req_ready_o,
   output logic [NumReq-1:0]         done_o,
   output logic [NumReq-1:0]         result_valid_o,
   output logic                      eng_start_valid_o,
   input  logic                      eng_start_ready_i,
   output logic                      eng_init_valid_o,
   input  logic                      eng_init_ready_i,
   input  logic                      eng_result_valid_i,
   output logic                      busy_o,
   output logic [$clog2(NumReq)-1:0] grant_idx_o,
   output logic                      beat_err_o
);
   localparam int IdxW = $clog2(NumReq);
   localparam int SumW = IdxW + 1;
   localparam int CntW = $clog2(ResultBeats + 1);
   localparam logic [CntW-1:0] BeatsExp = CntW'(ResultBeats);
   localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumReq - 1);
   localparam logic [SumW-1:0] NumReqW  = SumW'(NumReq);

   typedef enum logic [1:0] {Idle, Issue, Busy, Done} state_t;

   state_t              state, state_nxt;
   logic [IdxW-1:0]     rr_ptr;
   logic [IdxW-1:0]     grant_idx;
   logic                kind;
   logic [CntW-1:0]     beat_cnt;
   logic                beat_err;
   logic                eng_ready;
   logic                beat_bad;
   logic [2*NumReq-1:0] rr_dbl;
   logic [NumReq-1:0]   rr_rot;
   logic [SumW-1:0]     pick_sum;
   logic [IdxW-1:0]     pick_idx;
   logic                pick_found;

   // Rotate the request vector so bit 0 is rr_ptr, then map the first hit back.
   always_comb begin
      rr_dbl     = {req_valid_i, req_valid_i} >> rr_ptr;
      rr_rot     = rr_dbl[NumReq-1:0];
      pick_found = 1'b0;
      pick_sum   = '0;
      for (int i = 0; i < NumReq; i++) begin
         if (!pick_found && rr_rot[i]) begin
            pick_found = 1'b1;
            pick_sum   = {1'b0, rr_ptr} + SumW'(i);
         end
      end
      if (pick_sum >= NumReqW) begin
         pick_sum = pick_sum - NumReqW;
      end
      pick_idx = pick_sum[IdxW-1:0];
   end

   assign eng_ready = kind ? eng_init_ready_i : eng_start_ready_i;
   assign beat_bad  = kind ? (beat_cnt != '0) : (beat_cnt != BeatsExp);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= Idle;
         rr_ptr    <= '0;
         grant_idx <= '0;
         kind      <= 1'b0;
         beat_cnt  <= '0;
         beat_err  <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            Idle: begin
               if (pick_found) begin
                  grant_idx <= pick_idx;
                  kind      <= req_init_i[pick_idx];
                  beat_cnt  <= '0;
               end
            end
            Busy: begin
               if (eng_result_valid_i && (beat_cnt != '1)) begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end
            Done: begin
               rr_ptr <= (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;
               if (beat_bad) begin
                  beat_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt         = state;
      req_ready_o       = '0;
      done_o            = '0;
      result_valid_o    = '0;
      eng_start_valid_o = 1'b0;
      eng_init_valid_o  = 1'b0;
      case (state)
         Idle: begin
            if (pick_found) begin
               state_nxt = Issue;
            end
         end
         Issue: begin
            eng_init_valid_o  = kind;
            eng_start_valid_o = !kind;
            if (eng_ready) begin
               req_ready_o[grant_idx] = 1'b1;
               state_nxt              = Busy;
            end
         end
         Busy: begin
            result_valid_o[grant_idx] = eng_result_valid_i;
            // Engine signals it is idle again by raising the same ready it used to accept.
            if (eng_ready) begin
               state_nxt = Done;
            end
         end
         Done: begin
            done_o[grant_idx] = 1'b1;
            state_nxt         = Idle;
         end
         default: state_nxt = Idle;
      endcase
   end

   assign busy_o      = (state != Idle);
   assign grant_idx_o = grant_idx;
   assign beat_err_o  = beat_err;

endmodule

// File: tb/tb_mlp_job_arbiter.sv
// Bench for mlp_job_arbiter: behavioural engine model plus a queue of expected jobs
// (owner, kind, beats) checked at each accept and done pulse.
module tb_mlp_job_arbiter;
   localparam int NumReq      = 4;
   localparam int ResultBeats = 256;
   localparam int IdxW        = $clog2(NumReq);

   typedef struct {
      int idx;
      bit kind;
      int beats;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [NumReq-1:0] req_valid;
   logic [NumReq-1:0] req_init;
   logic [NumReq-1:0] req_ready_o;
   logic [NumReq-1:0] done_o;
   logic [NumReq-1:0] result_valid_o;
   logic              eng_start_valid_o;
   logic              eng_start_ready;
   logic              eng_init_valid_o;
   logic              eng_init_ready;
   logic              eng_result_valid;
   logic              busy_o;
   logic [IdxW-1:0]   grant_idx_o;
   logic              beat_err_o;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   int   eng_beats;
   int   eng_stall;

   int                issue_cnt, issue_len, ready_pulses, beat_own, beat_stray;
   logic [NumReq-1:0] mon_oh;
   exp_t              mon_e;

   always #5 clk = ~clk;

   mlp_job_arbiter #(.NumReq(NumReq), .ResultBeats(ResultBeats)) dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .req_valid_i        (req_valid),
      .req_init_i         (req_init),
      .req_ready_o        (req_ready_o),
      .done_o             (done_o),
      .result_valid_o     (result_valid_o),
      .eng_start_valid_o  (eng_start_valid_o),
      .eng_start_ready_i  (eng_start_ready),
      .eng_init_valid_o   (eng_init_valid_o),
      .eng_init_ready_i   (eng_init_ready),
      .eng_result_valid_i (eng_result_valid),
      .busy_o             (busy_o),
      .grant_idx_o        (grant_idx_o),
      .beat_err_o         (beat_err_o)
   );

   // Engine: accepts when idle, emits eng_beats beats per start job, then raises ready.
   initial begin
      int left;
      bit busy_e, acc_s, acc_i, any_v;
      left             = 0;
      busy_e           = 0;
      acc_s            = 0;
      acc_i            = 0;
      any_v            = 0;
      eng_start_ready  = 1'b1;
      eng_init_ready   = 1'b1;
      eng_result_valid = 1'b0;
      forever begin
         @(negedge clk);
         acc_s = eng_start_valid_o && eng_start_ready;
         acc_i = eng_init_valid_o && eng_init_ready;
         any_v = eng_start_valid_o || eng_init_valid_o;
         @(posedge clk);
         #1;
         if (rst) begin
            busy_e = 0; left = 0; eng_stall = 0;
            eng_result_valid = 1'b0;
            eng_start_ready  = 1'b1;
            eng_init_ready   = 1'b1;
         end else if (busy_e) begin
            if (left > 0) begin
               eng_result_valid = 1'b1;
               left--;
            end else begin
               eng_result_valid = 1'b0;
               busy_e = 0;
               eng_start_ready = 1'b1;
               eng_init_ready  = 1'b1;
            end
         end else if (acc_s || acc_i) begin
            busy_e = 1;
            left   = acc_s ? eng_beats : 0;
            eng_start_ready = 1'b0;
            eng_init_ready  = 1'b0;
         end else begin
            if (any_v && eng_stall > 0) eng_stall--;
            eng_start_ready = (eng_stall == 0);
            eng_init_ready  = (eng_stall == 0);
         end
      end
   end

   // Scoreboard monitor: grant owner/kind at accept; owner, beat count, pulse count at done.
   initial begin
      issue_cnt = 0; issue_len = 0; ready_pulses = 0; beat_own = 0; beat_stray = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            issue_cnt = 0; ready_pulses = 0; beat_own = 0; beat_stray = 0;
         end else begin
            if (eng_start_valid_o || eng_init_valid_o) issue_cnt++;
            if (req_ready_o != '0) begin
               issue_len = issue_cnt;
               issue_cnt = 0;
               ready_pulses++;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_grant req_ready=%b required none", req_ready_o);
               end else begin
                  mon_oh = NumReq'(1) << exp_q[0].idx;
                  if (req_ready_o !== mon_oh) begin
                     errors++;
                     $display("FAIL grant_owner req_ready=%b required %b", req_ready_o, mon_oh);
                  end
                  checks++;
                  if ({eng_init_valid_o, eng_start_valid_o} !== {exp_q[0].kind, ~exp_q[0].kind}) begin
                     errors++;
                     $display("FAIL job_kind init/start=%b%b required %b%b", eng_init_valid_o,
                              eng_start_valid_o, exp_q[0].kind, ~exp_q[0].kind);
                  end
               end
            end
            if (exp_q.size() > 0) begin
               mon_oh = NumReq'(1) << exp_q[0].idx;
               if ((result_valid_o & mon_oh) != '0) beat_own++;
               beat_stray += $countones(result_valid_o & ~mon_oh);
            end else begin
               beat_stray += $countones(result_valid_o);
            end
            if (done_o != '0) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_done done=%b required none", done_o);
               end else begin
                  mon_e  = exp_q.pop_front();
                  mon_oh = NumReq'(1) << mon_e.idx;
                  if (done_o !== mon_oh) begin
                     errors++;
                     $display("FAIL done_owner done=%b required %b", done_o, mon_oh);
                  end
                  checks++;
                  if (beat_own !== mon_e.beats) begin
                     errors++;
                     $display("FAIL owner_beats got %0d required %0d", beat_own, mon_e.beats);
                  end
                  checks++;
                  if (ready_pulses !== 1) begin
                     errors++;
                     $display("FAIL ready_pulses got %0d required 1", ready_pulses);
                  end
                  checks++;
                  if (beat_stray !== 0) begin
                     errors++;
                     $display("FAIL stray_beats got %0d required 0", beat_stray);
                  end
               end
               ready_pulses = 0; beat_own = 0; beat_stray = 0;
            end
         end
      end
   end

   task automatic push_job(input int idx, input bit kind, input int beats);
      exp_t e;
      e.idx = idx; e.kind = kind; e.beats = beats;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // once: requesters that drop valid after their accept; hold: kept asserted throughout.
   task automatic run_jobs(input logic [NumReq-1:0] once, input logic [NumReq-1:0] hold,
                           input int budget);
      int cyc = 0;
      logic [NumReq-1:0] pend = once;
      req_valid = pend | hold;
      while (exp_q.size() != 0 && cyc < budget) begin
         @(negedge clk);
         pend      = pend & ~req_ready_o;
         req_valid = pend | hold;
         cyc++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL job_timeout pending=%0d required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (req_ready_o !== '0) begin errors++; $display("FAIL rst_req_ready got %b required 0", req_ready_o); end
      checks++; if (done_o !== '0) begin errors++; $display("FAIL rst_done got %b required 0", done_o); end
      checks++; if (result_valid_o !== '0) begin errors++; $display("FAIL rst_result got %b required 0", result_valid_o); end
      checks++; if (eng_start_valid_o !== 1'b0) begin errors++; $display("FAIL rst_start got %b required 0", eng_start_valid_o); end
      checks++; if (eng_init_valid_o !== 1'b0) begin errors++; $display("FAIL rst_init got %b required 0", eng_init_valid_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b required 0", busy_o); end
      checks++; if (grant_idx_o !== '0) begin errors++; $display("FAIL rst_grant got %0d required 0", grant_idx_o); end
      checks++; if (beat_err_o !== 1'b0) begin errors++; $display("FAIL rst_beat_err got %b required 0", beat_err_o); end
   endtask

   task automatic test_single_start();
      req_init  = '0;
      eng_beats = ResultBeats;
      push_job(1, 1'b0, ResultBeats);
      run_jobs(4'b0010, 4'b0000, 600);
      @(negedge clk);
      checks++; if (beat_err_o !== 1'b0) begin errors++; $display("FAIL start_beat_err got %b required 0", beat_err_o); end
      checks++; if (grant_idx_o !== 2'd1) begin errors++; $display("FAIL start_grant got %0d required 1", grant_idx_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL start_idle_busy got %b required 0", busy_o); end
   endtask

   task automatic test_init();
      req_init = 4'b1000;
      push_job(3, 1'b1, 0);
      run_jobs(4'b1000, 4'b0000, 100);
      @(negedge clk);
      req_init = '0;
      checks++; if (grant_idx_o !== 2'd3) begin errors++; $display("FAIL init_grant got %0d required 3", grant_idx_o); end
      checks++; if (beat_err_o !== 1'b0) begin errors++; $display("FAIL init_beat_err got %b required 0", beat_err_o); end
   endtask

   // First half relies on rr_ptr having wrapped to 0 after the init job on requester 3.
   task automatic test_round_robin();
      eng_beats = ResultBeats;
      push_job(0, 1'b0, ResultBeats); push_job(2, 1'b0, ResultBeats);
      push_job(0, 1'b0, ResultBeats); push_job(2, 1'b0, ResultBeats);
      run_jobs(4'b0000, 4'b0101, 1600);
      do_reset();
      for (int i = 0; i < 5; i++) push_job(i % NumReq, 1'b0, ResultBeats);
      run_jobs(4'b0000, 4'b1111, 2000);
      do_reset();
   endtask

   task automatic test_backpressure();
      eng_stall = 5;
      push_job(0, 1'b0, ResultBeats);
      run_jobs(4'b0001, 4'b0000, 600);
      @(negedge clk);
      checks++; if (issue_len !== 6) begin errors++; $display("FAIL issue_hold got %0d required 6", issue_len); end
   endtask

   task automatic test_beat_error();
      eng_beats = ResultBeats - 1;
      push_job(1, 1'b0, ResultBeats - 1);
      run_jobs(4'b0010, 4'b0000, 600);
      @(negedge clk);
      checks++; if (beat_err_o !== 1'b1) begin errors++; $display("FAIL short_beat_err got %b required 1", beat_err_o); end
      eng_beats = ResultBeats;
      push_job(2, 1'b0, ResultBeats);
      run_jobs(4'b0100, 4'b0000, 600);
      @(negedge clk);
      checks++; if (beat_err_o !== 1'b1) begin errors++; $display("FAIL sticky_beat_err got %b required 1", beat_err_o); end
   endtask

   task automatic test_reset_mid_job();
      int cyc = 0;
      eng_beats = ResultBeats;
      push_job(2, 1'b0, ResultBeats);
      req_valid = 4'b0100;
      while (!req_ready_o[2] && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      req_valid = '0;
      checks++;
      if (!req_ready_o[2]) begin errors++; $display("FAIL abort_accept got 0 required 1"); end
      repeat (20) @(negedge clk);
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL abort_busy got %b required 1", busy_o); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy_clr got %b required 0", busy_o); end
      checks++; if (done_o !== '0) begin errors++; $display("FAIL abort_done got %b required 0", done_o); end
      checks++; if (result_valid_o !== '0) begin errors++; $display("FAIL abort_result got %b required 0", result_valid_o); end
      checks++; if ({eng_start_valid_o, eng_init_valid_o} !== 2'b00) begin errors++; $display("FAIL abort_eng_valid got %b%b required 00", eng_start_valid_o, eng_init_valid_o); end
      checks++; if (grant_idx_o !== '0) begin errors++; $display("FAIL abort_grant got %0d required 0", grant_idx_o); end
      checks++; if (beat_err_o !== 1'b0) begin errors++; $display("FAIL abort_beat_err got %b required 0", beat_err_o); end
      rst = 1'b0;
      exp_q.delete();
      push_job(1, 1'b0, ResultBeats);
      push_job(3, 1'b0, ResultBeats);
      run_jobs(4'b1010, 4'b0000, 1000);
      @(negedge clk);
      checks++; if (grant_idx_o !== 2'd3) begin errors++; $display("FAIL post_abort_grant got %0d required 3", grant_idx_o); end
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_init  = '0;
      eng_beats = ResultBeats;
      eng_stall = 0;
      test_reset();
      test_single_start();
      test_init();
      test_round_robin();
      test_backpressure();
      test_beat_error();
      test_reset_mid_job();
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
